// File: rtl/cic_comp_fir.sv
// Time-multiplexed 9-tap droop compensation FIR for the CIC3 decimator.
// Optional build macro CIC_COMP_DECIM2_EN: extra decimate-by-2 on the output.
module cic_comp_fir #(
    parameter int in_width   = 21,
    parameter int out_width  = 16,
    parameter int coef_width = 16,
    parameter int TAPS       = 9,
    parameter int SHIFT      = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [in_width-1:0]  in,
    output logic signed [out_width-1:0] out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int PROD_W = in_width + coef_width;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int PW     = $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t                       state;
    logic signed [in_width-1:0]   dl [TAPS];
    logic [PW-1:0]                wp;
    logic [PW-1:0]                wp_nxt;
    logic [PW-1:0]                k;
    logic [PW:0]                  rd_sum;
    logic [PW-1:0]                rd_idx;
    logic signed [ACC_W-1:0]      acc;
    logic signed [coef_width-1:0] coef;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      rsum;
    logic signed [ACC_W-1:0]      rsh;
    logic [ACC_W-out_width:0]     hi;
    logic signed [out_width-1:0]  sat;
    logic                         accept;
    logic                         start;

    always_comb begin
        coef = '0;
        case (k)
            PW'(0): coef = coef_width'(-256);
            PW'(1): coef = coef_width'(512);
            PW'(2): coef = coef_width'(-1024);
            PW'(3): coef = coef_width'(2048);
            PW'(4): coef = coef_width'(13824);
            PW'(5): coef = coef_width'(2048);
            PW'(6): coef = coef_width'(-1024);
            PW'(7): coef = coef_width'(512);
            PW'(8): coef = coef_width'(-256);
            default: coef = '0;
        endcase
    end

    // x[k] lives at (wp - 1 - k) mod TAPS once wp has advanced past the newest sample
    always_comb begin
        rd_sum = {1'b0, wp} + (PW+1)'(TAPS - 1) - {1'b0, k};
        if (rd_sum >= (PW+1)'(TAPS))
            rd_idx = PW'(rd_sum - (PW+1)'(TAPS));
        else
            rd_idx = rd_sum[PW-1:0];
        prod = PROD_W'(dl[rd_idx]) * PROD_W'(coef);
    end

    always_comb begin
        rsum = acc + ACC_W'(2 ** (SHIFT - 1));
        rsh  = rsum >>> SHIFT;
        hi   = rsh[ACC_W-1:out_width-1];
        if (&hi || ~|hi)
            sat = rsh[out_width-1:0];
        else if (rsh[ACC_W-1])
            sat = {1'b1, {(out_width-1){1'b0}}};
        else
            sat = {1'b0, {(out_width-1){1'b1}}};
    end

    assign wp_nxt = (wp == PW'(TAPS - 1)) ? '0 : wp + 1'b1;
    assign accept = in_valid && (state == IDLE);

`ifdef CIC_COMP_DECIM2_EN
    logic phase;

    assign start = accept && phase;

    always_ff @(posedge clk) begin
        if (reset)
            phase <= 1'b0;
        else if (accept)
            phase <= ~phase;
    end
`else
    assign start = accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wp        <= '0;
            k         <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < TAPS; i++)
                dl[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && state != IDLE)
                overrun <= 1'b1;
            if (accept) begin
                dl[wp] <= in;
                wp     <= wp_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == PW'(TAPS - 1))
                        state <= ROUND;
                    else
                        k <= k + 1'b1;
                end
                ROUND: begin
                    out       <= sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir; honours CIC_COMP_DECIM2_EN.
module tb_cic_comp_fir;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [20:0] din;
    logic signed [15:0] dout;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int fails  = 0;
    int lat;
    int o;
    int n_ov;

    int exp_imp[10] = '{-256, 512, -1024, 2048, 13824, 2048, -1024, 512, -256, 0};
    int exp_sp[10]  = '{-16384, 16384, -32768, 32767, 32767,
                        32767, 32767, 32767, 32767, 32767};
    int exp_sn[10]  = '{16384, -16384, 32767, -32768, -32768,
                        -32768, -32768, -32768, -32768, -32768};
    int exp_k1[5]   = '{-16, 31, -62, 125, 844};
    int exp_d2[5]   = '{512, 2048, 2048, 512, 0};

    cic_comp_fir dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (din),
        .out       (dout),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #2 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        din      = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int v, output int l, output int r);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 21'(v);
        @(negedge clk);
        in_valid = 1'b0;
        din      = '0;
        l        = 1;
        while (!out_valid && l < 20) begin
            @(negedge clk);
            l++;
        end
        r = dout;
    endtask

    task automatic send_wo(input int v);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 21'(v);
        @(negedge clk);
        in_valid = 1'b0;
        din      = '0;
        check("wo_busy", busy, 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        din      = '0;
        do_reset();
        check("rst_out", dout, 0);
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

`ifdef CIC_COMP_DECIM2_EN
        send_wo(16384);
        for (int i = 0; i < 5; i++) begin
            send(0, lat, o);
            check($sformatf("d2_out%0d", i), o, exp_d2[i]);
            check($sformatf("d2_lat%0d", i), lat, 11);
            if (i < 4)
                send_wo(0);
        end
        check("d2_overrun", overrun, 0);
`else
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16384 : 0, lat, o);
            check($sformatf("imp_out%0d", i), o, exp_imp[i]);
            check($sformatf("imp_lat%0d", i), lat, 11);
        end
        check("imp_overrun", overrun, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(1000, lat, o);
            if (i == 0)
                check("dc_first", o, -16);
            if (i >= 8)
                check($sformatf("dc_pos%0d", i), o, 1000);
        end
        for (int i = 0; i < 10; i++) begin
            send(-1000, lat, o);
            if (i >= 8)
                check($sformatf("dc_neg%0d", i), o, -1000);
        end

        @(negedge clk);
        in_valid = 1'b1;
        din      = 21'(16384);
        @(negedge clk);
        in_valid = 1'b0;
        din      = '0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_out", dout, 0);
        check("mid_busy", busy, 0);
        n_ov = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid)
                n_ov++;
        end
        check("mid_no_valid", n_ov, 0);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 16384 : 0, lat, o);
            check($sformatf("mid_imp%0d", i), o, exp_imp[i]);
        end

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(1048575, lat, o);
            check($sformatf("satp%0d", i), o, exp_sp[i]);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(-1048576, lat, o);
            check($sformatf("satn%0d", i), o, exp_sn[i]);
        end

        do_reset();
        check("ovr_init", overrun, 0);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 21'(1000);
        @(negedge clk);
        in_valid = 1'b0;
        din      = '0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 21'(5000);
        check("ovr_busy", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        din      = '0;
        check("ovr_set", overrun, 1);
        lat = 4;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ovr_lat", lat, 11);
        check("ovr_out0", dout, exp_k1[0]);
        for (int i = 1; i < 5; i++) begin
            send(0, lat, o);
            check($sformatf("ovr_out%0d", i), o, exp_k1[i]);
        end
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_clear", overrun, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
